// File: rtl/memory_accessor_pipelined.sv
// Pipelined MA_PEEK/MA_POKE memory accessor: up to DEPTH requests in flight,
// worker-results returned in request order, optional suppression of poke results.
module memory_accessor_pipelined #(
  parameter int PACKET_WIDTH        = 96,
  parameter int WORKER_RESULT_WIDTH = 56,
  parameter int DATA_WIDTH          = 32,
  parameter int DEPTH               = 4,
  parameter bit POKE_RESULT         = 1'b1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           RECEIVE_PC_VALID,
  input  logic [PACKET_WIDTH-1:0]        RECEIVE_PC_DATA,
  output logic                           RECEIVE_PC_READY,
  output logic                           MEM_SEND_ADDR_VALID,
  output logic [DATA_WIDTH-1:0]          MEM_SEND_ADDR,
  output logic                           MEM_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]          MEM_SEND_DATA,
  input  logic                           MEM_SEND_READY,
  input  logic                           MEM_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]          MEM_RECEIVE_DATA,
  output logic                           MEM_RECEIVE_READY,
  output logic                           SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0] SEND_WR_DATA,
  input  logic                           SEND_WR_READY,
  output logic [$clog2(DEPTH+1)-1:0]     INFLIGHT,
  output logic                           BAD_OPCODE
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int CTX_W = 2 + 6 + 16 + 1;
  localparam int F0    = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    MA_PEEK = 8'h01;
  localparam logic [7:0]    MA_POKE = 8'h02;

  // Packet layout, LSB first: data2, data1, color[16], dest_addr[6], dest_option[2], opcode[8].
  function automatic logic [7:0] pkt_opcode(input logic [PACKET_WIDTH-1:0] p);
    return p[F0+24 +: 8];
  endfunction

  function automatic logic [1:0] pkt_dest_option(input logic [PACKET_WIDTH-1:0] p);
    return p[F0+22 +: 2];
  endfunction

  function automatic logic [5:0] pkt_dest_addr(input logic [PACKET_WIDTH-1:0] p);
    return p[F0+16 +: 6];
  endfunction

  function automatic logic [15:0] pkt_color(input logic [PACKET_WIDTH-1:0] p);
    return p[F0 +: 16];
  endfunction

  function automatic logic [WORKER_RESULT_WIDTH-1:0] make_worker_result(
    input logic [1:0]            dopt,
    input logic [5:0]            daddr,
    input logic [15:0]           color,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [WORKER_RESULT_WIDTH-1:0] r;
    r = '0;
    r[DATA_WIDTH-1:0]       = data;
    r[DATA_WIDTH +: 16]     = color;
    r[DATA_WIDTH+16 +: 6]   = daddr;
    r[DATA_WIDTH+22 +: 2]   = dopt;
    return r;
  endfunction

  logic                           req_v_r;
  logic                           req_poke_r;
  logic [DATA_WIDTH-1:0]          req_addr_r;
  logic [DATA_WIDTH-1:0]          req_data_r;
  logic [1:0]                     req_dopt_r;
  logic [5:0]                     req_daddr_r;
  logic [15:0]                    req_color_r;
  logic [CW-1:0]                  inflight_r;
  logic [CTX_W-1:0]               ctx_mem_r [DEPTH];
  logic [PW-1:0]                  wr_ptr_r;
  logic [PW-1:0]                  rd_ptr_r;
  logic [CW-1:0]                  ctx_cnt_r;
  logic                           wr_valid_r;
  logic [WORKER_RESULT_WIDTH-1:0] wr_data_r;
  logic                           bad_r;

  logic             op_peek_s;
  logic             op_poke_s;
  logic             pc_ready_s;
  logic             accept_s;
  logic             load_s;
  logic             bad_s;
  logic             send_hs_s;
  logic             ctx_nonempty_s;
  logic             resp_ready_s;
  logic             resp_hs_s;
  logic             wr_ld_s;
  logic [CTX_W-1:0] ctx_head_s;
  logic [CTX_W-1:0] ctx_push_s;

  // Handshake qualification and context FIFO head/push words.
  always_comb begin
    op_peek_s      = (pkt_opcode(RECEIVE_PC_DATA) == MA_PEEK);
    op_poke_s      = (pkt_opcode(RECEIVE_PC_DATA) == MA_POKE);
    pc_ready_s     = (inflight_r < DEPTH_C) && (!req_v_r || MEM_SEND_READY);
    accept_s       = RECEIVE_PC_VALID && pc_ready_s;
    load_s         = accept_s && (op_peek_s || op_poke_s);
    bad_s          = accept_s && !(op_peek_s || op_poke_s);
    send_hs_s      = req_v_r && MEM_SEND_READY;
    ctx_nonempty_s = (ctx_cnt_r != '0);
    resp_ready_s   = ctx_nonempty_s && (!wr_valid_r || SEND_WR_READY);
    resp_hs_s      = MEM_RECEIVE_VALID && resp_ready_s;
    ctx_head_s     = ctx_mem_r[rd_ptr_r];
    wr_ld_s        = resp_hs_s && !ctx_head_s[0];
    ctx_push_s     = {req_dopt_r, req_daddr_r, req_color_r,
                      req_poke_r && (POKE_RESULT == 1'b0)};
  end

  // Request stage: a new accept may refill it in the same cycle it is sent.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_v_r     <= 1'b0;
      req_poke_r  <= 1'b0;
      req_addr_r  <= '0;
      req_data_r  <= '0;
      req_dopt_r  <= 2'd0;
      req_daddr_r <= 6'd0;
      req_color_r <= 16'd0;
    end else if (load_s) begin
      req_v_r     <= 1'b1;
      req_poke_r  <= op_poke_s;
      req_addr_r  <= RECEIVE_PC_DATA[DATA_WIDTH +: DATA_WIDTH];
      req_data_r  <= RECEIVE_PC_DATA[DATA_WIDTH-1:0];
      req_dopt_r  <= pkt_dest_option(RECEIVE_PC_DATA);
      req_daddr_r <= pkt_dest_addr(RECEIVE_PC_DATA);
      req_color_r <= pkt_color(RECEIVE_PC_DATA);
    end else if (send_hs_s) begin
      req_v_r     <= 1'b0;
    end else begin
      req_v_r     <= req_v_r;
    end
  end

  // In-flight credit counter: accepted-but-unanswered requests.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight_r <= '0;
    end else begin
      case ({load_s, resp_hs_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Context FIFO; overflow is excluded by the credit counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) ctx_mem_r[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      ctx_cnt_r <= '0;
    end else begin
      if (send_hs_s) begin
        ctx_mem_r[wr_ptr_r] <= ctx_push_s;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (resp_hs_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({send_hs_s, resp_hs_s})
        2'b10:   ctx_cnt_r <= ctx_cnt_r + CW'(1);
        2'b01:   ctx_cnt_r <= ctx_cnt_r - CW'(1);
        default: ctx_cnt_r <= ctx_cnt_r;
      endcase
    end
  end

  // Result register and bad-opcode pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_valid_r <= 1'b0;
      wr_data_r  <= '0;
      bad_r      <= 1'b0;
    end else begin
      bad_r <= bad_s;
      if (wr_ld_s) begin
        wr_valid_r <= 1'b1;
        wr_data_r  <= make_worker_result(ctx_head_s[CTX_W-1 -: 2], ctx_head_s[CTX_W-3 -: 6],
                                         ctx_head_s[CTX_W-9 -: 16], MEM_RECEIVE_DATA);
      end else if (SEND_WR_READY) begin
        wr_valid_r <= 1'b0;
      end else begin
        wr_valid_r <= wr_valid_r;
      end
    end
  end

  assign RECEIVE_PC_READY    = pc_ready_s;
  assign MEM_SEND_ADDR_VALID = req_v_r;
  assign MEM_SEND_ADDR       = req_addr_r;
  assign MEM_SEND_DATA_VALID = req_v_r && req_poke_r;
  assign MEM_SEND_DATA       = req_data_r;
  assign MEM_RECEIVE_READY   = resp_ready_s;
  assign SEND_WR_VALID       = wr_valid_r;
  assign SEND_WR_DATA        = wr_data_r;
  assign INFLIGHT            = inflight_r;
  assign BAD_OPCODE          = bad_r;

endmodule

// File: tb/tb_memory_accessor_pipelined.sv
// Bench for memory_accessor_pipelined: queue-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_memory_accessor_pipelined;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // DUT A (POKE_RESULT = 1) signals
  logic        pc_valid = 1'b0;
  logic [95:0] pc_data = '0;
  logic        pc_ready, av, dv, mrr, wrv, bad;
  logic [31:0] addr, wdata;
  logic        mem_ready = 1'b1;
  logic        mrv = 1'b0;
  logic [31:0] mrd = '0;
  logic        wr_ready = 1'b1;
  logic [55:0] wrd;
  logic [2:0]  infl;

  // DUT B (POKE_RESULT = 0) signals
  logic        b_pc_valid = 1'b0;
  logic [95:0] b_pc_data = '0;
  logic        b_pc_ready, b_av, b_dv, b_mrr, b_wrv, b_bad;
  logic [31:0] b_addr, b_wdata;
  logic        b_mrv = 1'b0;
  logic [31:0] b_mrd = '0;
  logic [55:0] b_wrd;
  logic [2:0]  b_infl;
  logic        b_done = 1'b0;

  memory_accessor_pipelined #(.PACKET_WIDTH(96), .WORKER_RESULT_WIDTH(56), .DATA_WIDTH(32),
                              .DEPTH(DEPTH), .POKE_RESULT(1'b1)) dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .RECEIVE_PC_VALID(pc_valid), .RECEIVE_PC_DATA(pc_data), .RECEIVE_PC_READY(pc_ready),
    .MEM_SEND_ADDR_VALID(av), .MEM_SEND_ADDR(addr), .MEM_SEND_DATA_VALID(dv),
    .MEM_SEND_DATA(wdata), .MEM_SEND_READY(mem_ready),
    .MEM_RECEIVE_VALID(mrv), .MEM_RECEIVE_DATA(mrd), .MEM_RECEIVE_READY(mrr),
    .SEND_WR_VALID(wrv), .SEND_WR_DATA(wrd), .SEND_WR_READY(wr_ready),
    .INFLIGHT(infl), .BAD_OPCODE(bad));

  memory_accessor_pipelined #(.PACKET_WIDTH(96), .WORKER_RESULT_WIDTH(56), .DATA_WIDTH(32),
                              .DEPTH(DEPTH), .POKE_RESULT(1'b0)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .RECEIVE_PC_VALID(b_pc_valid), .RECEIVE_PC_DATA(b_pc_data), .RECEIVE_PC_READY(b_pc_ready),
    .MEM_SEND_ADDR_VALID(b_av), .MEM_SEND_ADDR(b_addr), .MEM_SEND_DATA_VALID(b_dv),
    .MEM_SEND_DATA(b_wdata), .MEM_SEND_READY(1'b1),
    .MEM_RECEIVE_VALID(b_mrv), .MEM_RECEIVE_DATA(b_mrd), .MEM_RECEIVE_READY(b_mrr),
    .SEND_WR_VALID(b_wrv), .SEND_WR_DATA(b_wrd), .SEND_WR_READY(1'b1),
    .INFLIGHT(b_infl), .BAD_OPCODE(b_bad));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mkpkt(input logic [7:0] op, input logic [1:0] dopt,
                                        input logic [5:0] da, input logic [15:0] col,
                                        input logic [31:0] a, input logic [31:0] d);
    return {op, dopt, da, col, a, d};
  endfunction

  // Transaction model: accepted-not-sent, sent-not-answered, results-not-delivered.
  typedef struct {
    logic [1:0]  dopt;
    logic [5:0]  daddr;
    logic [15:0] color;
    logic        poke;
    logic [31:0] a;
    logic [31:0] d;
    int          due;
  } ent_t;

  ent_t        iss_q[$];
  ent_t        out_q[$];
  logic [55:0] res_q[$];
  logic [15:0] delivered[$];
  logic [55:0] last_res = '0;
  logic        exp_bad = 1'b0;
  int          mem_lat = 0;
  int          bad_pulses = 0;
  int          av_cycles = 0;
  int          max_infl = 0;

  // Memory contents as seen by the bench's memory: pokes echo write data.
  function automatic logic [31:0] resp_of(input ent_t e);
    if (e.poke) return e.d;
    if (e.a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return e.a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [55:0] mk_res(input ent_t e);
    return {e.dopt, e.daddr, e.color, resp_of(e)};
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Bench memory: answers in order once the head request is due.
  always @(posedge CLK) begin
    #1;
    if (RST_N && out_q.size() > 0 && out_q[0].due <= cyc) begin
      mrv = 1'b1;
      mrd = resp_of(out_q[0]);
    end else begin
      mrv = 1'b0;
      mrd = '0;
    end
  end

  ent_t m_e;
  int   m_infl;
  bit   m_pcr, m_mrr, m_acc, m_snd, m_rsp, m_wrh;

  // Per-cycle compare against the model, then advance the model by this cycle's handshakes.
  always @(negedge CLK) begin
    if (!RST_N) begin
      iss_q.delete();
      out_q.delete();
      res_q.delete();
      exp_bad = 1'b0;
    end else begin
      m_infl = iss_q.size() + out_q.size();
      m_pcr  = (m_infl < DEPTH) && (iss_q.size() == 0 || mem_ready);
      m_mrr  = (out_q.size() > 0) && (res_q.size() == 0 || wr_ready);
      chk("inflight", infl, m_infl);
      chk("pc_ready", pc_ready, m_pcr);
      chk("addr_valid", av, iss_q.size() > 0);
      if (iss_q.size() > 0) begin
        chk("send_addr", addr, iss_q[0].a);
        chk("data_valid", dv, iss_q[0].poke);
        if (iss_q[0].poke) chk("send_data", wdata, iss_q[0].d);
      end
      chk("mem_rx_ready", mrr, m_mrr);
      chk("wr_valid", wrv, res_q.size() > 0);
      if (res_q.size() > 0) chk("wr_data", wrd, res_q[0]);
      chk("bad_opcode", bad, exp_bad);
      if (bad) bad_pulses++;
      if (av) av_cycles++;
      if (m_infl > max_infl) max_infl = m_infl;

      m_acc = pc_valid && m_pcr;
      m_snd = (iss_q.size() > 0) && mem_ready;
      m_rsp = mrv && m_mrr;
      m_wrh = (res_q.size() > 0) && wr_ready;
      if (m_wrh) begin
        delivered.push_back(res_q[0][47:32]);
        last_res = res_q.pop_front();
      end
      if (m_rsp) begin
        m_e = out_q.pop_front();
        res_q.push_back(mk_res(m_e));
      end
      if (m_snd) begin
        m_e = iss_q.pop_front();
        m_e.due = cyc + 1 + mem_lat;
        out_q.push_back(m_e);
      end
      exp_bad = 1'b0;
      if (m_acc) begin
        if (pc_data[95:88] == 8'h01 || pc_data[95:88] == 8'h02) begin
          m_e.poke  = (pc_data[95:88] == 8'h02);
          m_e.dopt  = pc_data[87:86];
          m_e.daddr = pc_data[85:80];
          m_e.color = pc_data[79:64];
          m_e.a     = pc_data[63:32];
          m_e.d     = pc_data[31:0];
          m_e.due   = 0;
          iss_q.push_back(m_e);
        end else begin
          exp_bad = 1'b1;
        end
      end
    end
  end

  // Present one packet until accepted; returns the acceptance cycle.
  task automatic push_pkt(input logic [95:0] p, output int t_acc);
    int n;
    n = 0;
    pc_valid = 1'b1;
    pc_data  = p;
    @(negedge CLK);
    while (!pc_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL push_timeout: got no ready expected ready within 100 cycles");
    end
    t_acc = cyc;
    @(posedge CLK);
    #1;
    pc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while ((iss_q.size() + out_q.size() + res_q.size()) != 0 && n < 300);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got busy expected idle within 300 cycles");
    end
  endtask

  // POKE_RESULT=0 instance: poke goes to memory, response is swallowed.
  initial begin
    wait (RST_N);
    @(posedge CLK); #1;
    b_pc_valid = 1'b1;
    b_pc_data  = mkpkt(8'h02, 2'd1, 6'd2, 16'h0099, 32'h40, 32'h55);
    @(negedge CLK);
    chk("b_accept_ready", b_pc_ready, 1'b1);
    @(posedge CLK); #1;
    b_pc_valid = 1'b0;
    @(negedge CLK);
    chk("b_addr_valid", b_av, 1'b1);
    chk("b_data_valid", b_dv, 1'b1);
    chk("b_send_addr", b_addr, 32'h40);
    chk("b_send_data", b_wdata, 32'h55);
    chk("b_inflight_1", b_infl, 3'd1);
    @(posedge CLK); #1;
    b_mrv = 1'b1;
    b_mrd = 32'h55;
    @(negedge CLK);
    chk("b_mem_rx_ready", b_mrr, 1'b1);
    @(posedge CLK); #1;
    b_mrv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("b_no_result", b_wrv, 1'b0);
      chk("b_inflight_0", b_infl, 3'd0);
    end
    chk("b_wr_data_reset", b_wrd, 56'h0);
    chk("b_bad", b_bad, 1'b0);
    b_done = 1'b1;
  end

  initial begin
    int t, n, bp0, av0;
    #12;
    chk("rst_inflight", infl, 3'd0);
    chk("rst_addr_valid", av, 1'b0);
    chk("rst_wr_valid", wrv, 1'b0);
    chk("rst_bad", bad, 1'b0);
    chk("rst_mem_rx_ready", mrr, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Single peek: result at T+3 carrying 0xDEADBEEF
    push_pkt(mkpkt(8'h01, 2'd1, 6'd5, 16'hABCD, 32'h100, 32'h0), t);
    n = 0;
    do begin @(negedge CLK); n++; end while (!wrv && n < 20);
    chk("peek_latency", cyc - t, 3);
    chk("peek_result", wrd, 56'h45_ABCD_DEADBEEF);
    wait_idle();
    chk("peek_inflight_0", infl, 3'd0);

    // Eight back-to-back peeks with 6-cycle memory latency
    mem_lat = 5;
    max_infl = 0;
    delivered.delete();
    for (int i = 0; i < 8; i++)
      push_pkt(mkpkt(8'h01, 2'd0, 6'(i), 16'h0010 + 16'(i), 32'h200 + 32'(4 * i), 32'h0), t);
    wait_idle();
    chk("burst_max_inflight", max_infl, 4);
    chk("burst_count", delivered.size(), 8);
    for (int i = 0; i < 8 && i < delivered.size(); i++)
      chk("burst_order", delivered[i], 16'h0010 + 16'(i));
    mem_lat = 0;

    // Poke with result
    push_pkt(mkpkt(8'h02, 2'd0, 6'd0, 16'h0077, 32'h40, 32'h55), t);
    @(negedge CLK);
    chk("poke_data_valid", dv, 1'b1);
    chk("poke_data", wdata, 32'h55);
    chk("poke_addr", addr, 32'h40);
    wait_idle();
    chk("poke_result", last_res, 56'h00_0077_0000_0055);
    chk("poke_inflight_0", infl, 3'd0);

    // Bad opcode
    bp0 = bad_pulses;
    av0 = av_cycles;
    push_pkt(mkpkt(8'hFF, 2'd3, 6'd1, 16'h0BAD, 32'h80, 32'h1), t);
    repeat (3) @(posedge CLK);
    #1;
    chk("bad_pulse_once", bad_pulses - bp0, 1);
    chk("bad_no_request", av_cycles - av0, 0);
    chk("bad_inflight", infl, 3'd0);

    // Downstream stall with three responses pending
    delivered.delete();
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_pkt(mkpkt(8'h01, 2'd2, 6'd3, 16'h0031 + 16'(i), 32'h300 + 32'(i), 32'h0), t);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("stall_mem_rx_ready", mrr, 1'b0);
    chk("stall_inflight", infl, 3'd2);
    chk("stall_wr_valid", wrv, 1'b1);
    @(posedge CLK); #1;
    wr_ready = 1'b1;
    wait_idle();
    chk("stall_count", delivered.size(), 3);
    for (int i = 0; i < 3 && i < delivered.size(); i++)
      chk("stall_order", delivered[i], 16'h0031 + 16'(i));

    n = 0;
    while (!b_done && n < 100) begin @(posedge CLK); n++; end
    chk("b_finished", b_done, 1'b1);

    // Reset with two requests in flight
    #1;
    mem_lat = 20;
    push_pkt(mkpkt(8'h01, 2'd0, 6'd1, 16'h0051, 32'h500, 32'h0), t);
    push_pkt(mkpkt(8'h01, 2'd0, 6'd2, 16'h0052, 32'h504, 32'h0), t);
    @(posedge CLK); #1;
    chk("pre_reset_inflight", infl, 3'd2);
    #1 RST_N = 1'b0;
    #1;
    chk("mid_rst_inflight", infl, 3'd0);
    chk("mid_rst_addr_valid", av, 1'b0);
    chk("mid_rst_data_valid", dv, 1'b0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_wr_valid", wrv, 1'b0);
    chk("mid_rst_mem_rx_ready", mrr, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    mem_lat = 0;
    push_pkt(mkpkt(8'h01, 2'd2, 6'd9, 16'h1234, 32'h100, 32'h0), t);
    wait_idle();
    chk("post_reset_result", last_res, 56'h89_1234_DEADBEEF);
    chk("post_reset_inflight", infl, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
